vx_ag_tcu_int_dpu: RTL and testbench

// - Parametrised integer dot-product unit for the AG tensor core: a TC_M x TC_N grid of lanes.
// - Each lane computes d[i][j] = c[i][j] + sum_k a[i][k]*b[j][k], with selectable packed formats.
// - Global-stall pipeline with a fixed LATENCY; tag and per-txn error flag ride alongside the data.
// - Sits between the AG TCU operand collector and the result arbiter; replaces the fixed-K int lane.

---
 rtl/vx_ag_tcu_int_dpu.sv | 218 +++++++++++++++++++++
 tb/tb_vx_ag_tcu_int_dpu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vx_ag_tcu_int_dpu.sv
// vx_ag_tcu_int_dpu: integer dot-product unit for the AG tensor core.
// A TC_M x TC_N grid of lanes computes d[i][j] = c[i][j] + sum_k a[i][k]*b[j][k]
// over packed int32 / int8 / uint8 / int4 words.
// The pipeline is LATENCY deep and stalls globally.
// Stage 0 registers the per-word products and stage 1 registers the reduced lane
// results. Any further stages are plain delay registers.
// Optional feature macro: AG_TCU_INT_SAT_EN. When it is defined, lanes that
// overflow int32 saturate instead of wrapping.
module vx_ag_tcu_int_dpu #(
    parameter int TC_M    = 2,
    parameter int TC_N    = 2,
    parameter int TC_K    = 4,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_fmt,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic [TC_M*TC_K*32-1:0]   in_a,
    input  logic [TC_N*TC_K*32-1:0]   in_b,
    input  logic [TC_M*TC_N*32-1:0]   in_c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAG_W-1:0]          out_tag,
    output logic [TC_M*TC_N*32-1:0]   out_d,
    output logic                      out_ovf
);

    localparam int LANES = TC_M * TC_N;
    localparam int WORDS = LANES * TC_K;
    // Wide enough that the exact lane sum never wraps, even for TC_K int32 products
    // of magnitude up to 2^62.
    localparam int ACC_W = 72;

    generate
        if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
            $error("vx_ag_tcu_int_dpu: LATENCY must be in 2..8");
        end
    endgenerate

    // Exact signed dot product of one 32-bit word pair under the selected packing.
    function automatic logic signed [63:0] word_dot(input logic [1:0]  fmt,
                                                    input logic [31:0] a,
                                                    input logic [31:0] b);
        logic signed [63:0] acc;
        acc = 64'sd0;
        case (fmt)
            2'd0: begin
                acc = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            end
            2'd1: begin
                for (int i = 0; i < 4; i++) begin
                    acc = acc + $signed({{56{a[8*i+7]}}, a[8*i +: 8]})
                              * $signed({{56{b[8*i+7]}}, b[8*i +: 8]});
                end
            end
            2'd2: begin
                for (int i = 0; i < 4; i++) begin
                    acc = acc + $signed({56'd0, a[8*i +: 8]})
                              * $signed({56'd0, b[8*i +: 8]});
                end
            end
            2'd3: begin
                for (int i = 0; i < 8; i++) begin
                    acc = acc + $signed({{60{a[4*i+3]}}, a[4*i +: 4]})
                              * $signed({{60{b[4*i+3]}}, b[4*i +: 4]});
                end
            end
            default: begin
                acc = 64'sd0;
            end
        endcase
        return acc;
    endfunction

    logic adv_s;
    logic in_fire_s;

    // Stage 0 holds the products and the accumulator input.
    logic                     s0_vld_q, s0_vld_d;
    logic [TAG_W-1:0]         s0_tag_q, s0_tag_d;
    logic [LANES*32-1:0]      s0_c_q, s0_c_d;
    logic signed [63:0]       s0_prod_q [WORDS];
    logic signed [63:0]       s0_prod_d [WORDS];

    // Stages 1..LATENCY-1 hold the finished lane results.
    logic [LATENCY-1:1]       vld_q, vld_d;
    logic [LATENCY-1:1]       ovf_q, ovf_d;
    logic [TAG_W-1:0]         tag_q  [1:LATENCY-1];
    logic [TAG_W-1:0]         tag_d  [1:LATENCY-1];
    logic [LANES*32-1:0]      dres_q [1:LATENCY-1];
    logic [LANES*32-1:0]      dres_d [1:LATENCY-1];

    // Reduction of stage 0 into per-lane results.
    logic signed [ACC_W-1:0]  lane_sum_s;
    logic [ACC_W-32:0]        lane_hi_s;
    logic                     lane_of_s;
    logic [LANES*32-1:0]      lane_d_s;
    logic                     lane_ovf_s;

    // Global stall: everything advances unless a result is waiting to be taken.
    always_comb begin
        adv_s     = ~vld_q[LATENCY-1] | out_ready;
        in_fire_s = in_valid & adv_s;
    end

    // Stage 0 next state: capture products when a txn is accepted.
    always_comb begin
        s0_vld_d  = s0_vld_q;
        s0_tag_d  = s0_tag_q;
        s0_c_d    = s0_c_q;
        s0_prod_d = s0_prod_q;
        if (adv_s) begin
            s0_vld_d = in_valid;
            if (in_fire_s) begin
                s0_tag_d = in_tag;
                s0_c_d   = in_c;
                for (int i = 0; i < TC_M; i++) begin
                    for (int j = 0; j < TC_N; j++) begin
                        for (int k = 0; k < TC_K; k++) begin
                            s0_prod_d[(i*TC_N + j)*TC_K + k] =
                                word_dot(in_fmt, in_a[(i*TC_K + k)*32 +: 32],
                                         in_b[(j*TC_K + k)*32 +: 32]);
                        end
                    end
                end
            end else begin
                s0_tag_d = s0_tag_q;
            end
        end else begin
            s0_vld_d = s0_vld_q;
        end
    end

    // Lane reduction: exact sum, int32 range check and wrap or saturate.
    always_comb begin
        lane_d_s   = '0;
        lane_ovf_s = 1'b0;
        lane_sum_s = '0;
        lane_hi_s  = '0;
        lane_of_s  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum_s = ACC_W'($signed(s0_c_q[l*32 +: 32]));
            for (int k = 0; k < TC_K; k++) begin
                lane_sum_s = lane_sum_s + ACC_W'(s0_prod_q[l*TC_K + k]);
            end
            lane_hi_s  = lane_sum_s[ACC_W-1:31];
            lane_of_s  = ~((&lane_hi_s) | ~(|lane_hi_s));
            lane_ovf_s = lane_ovf_s | lane_of_s;
`ifdef AG_TCU_INT_SAT_EN
            if (lane_of_s) begin
                lane_d_s[l*32 +: 32] = lane_sum_s[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                lane_d_s[l*32 +: 32] = lane_sum_s[31:0];
            end
`else
            lane_d_s[l*32 +: 32] = lane_sum_s[31:0];
`endif
        end
    end

    // Result stages next state: load stage 1 from the reduction, shift the rest.
    always_comb begin
        vld_d  = vld_q;
        ovf_d  = ovf_q;
        tag_d  = tag_q;
        dres_d = dres_q;
        if (adv_s) begin
            vld_d[1]  = s0_vld_q;
            ovf_d[1]  = s0_vld_q & lane_ovf_s;
            tag_d[1]  = s0_tag_q;
            dres_d[1] = lane_d_s;
            for (int k = 2; k < LATENCY; k++) begin
                vld_d[k]  = vld_q[k-1];
                ovf_d[k]  = ovf_q[k-1];
                tag_d[k]  = tag_q[k-1];
                dres_d[k] = dres_q[k-1];
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Control flops: the valid and overflow bits are cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_vld_q <= 1'b0;
            vld_q    <= '0;
            ovf_q    <= '0;
        end else begin
            s0_vld_q <= s0_vld_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // Datapath flops: the contents are qualified by the valid bits, so they have no reset.
    always_ff @(posedge clk) begin
        s0_tag_q  <= s0_tag_d;
        s0_c_q    <= s0_c_d;
        s0_prod_q <= s0_prod_d;
        tag_q     <= tag_d;
        dres_q    <= dres_d;
    end

    // Outputs come straight from the last stage register.
    always_comb begin
        in_ready  = adv_s;
        out_valid = vld_q[LATENCY-1];
        out_ovf   = ovf_q[LATENCY-1];
        out_tag   = tag_q[LATENCY-1];
        out_d     = dres_q[LATENCY-1];
    end

endmodule

// File: tb/tb_vx_ag_tcu_int_dpu.sv
// Directed self-checking bench for vx_ag_tcu_int_dpu (default parameters).
// Build with AG_TCU_INT_SAT_EN defined to check the saturating variant.
module tb_vx_ag_tcu_int_dpu;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_fmt;
    logic [7:0]   in_tag;
    logic [255:0] in_a;
    logic [255:0] in_b;
    logic [127:0] in_c;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_tag;
    logic [127:0] out_d;
    logic         out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_ag_tcu_int_dpu #(
        .TC_M(2), .TC_N(2), .TC_K(4), .LATENCY(LAT), .TAG_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_tag(in_tag),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_d(out_d), .out_ovf(out_ovf)
    );

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one txn into an empty pipe and check latency, tag, data and overflow.
    task automatic run_one(input string name, input logic [1:0] fmt, input logic [255:0] a,
                           input logic [255:0] b, input logic [127:0] c, input logic [7:0] tag,
                           input logic [127:0] exp_d, input logic exp_ovf);
        int waited;
        in_fmt    = fmt;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        in_tag    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        waited   = 1;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk({name, "_valid"}, 128'(out_valid), 128'(1'b1));
        chk({name, "_lat"}, 128'(waited), 128'(LAT));
        chk({name, "_tag"}, 128'(out_tag), 128'(tag));
        chk({name, "_d"}, out_d, exp_d);
        chk({name, "_ovf"}, 128'(out_ovf), 128'(exp_ovf));
        tick();
    endtask

    logic [127:0] ovf_pos_exp;
    logic [127:0] ovf_neg_exp;
    logic [127:0] prev_d;
    logic         prev_stall;
    int           sent;
    int           rcvd;
    int           t;

    initial begin
`ifdef AG_TCU_INT_SAT_EN
        ovf_pos_exp = {4{32'h7FFF_FFFF}};
        ovf_neg_exp = {4{32'h8000_0000}};
`else
        ovf_pos_exp = {4{32'h0000_0004}};
        ovf_neg_exp = {4{32'h0000_0000}};
`endif
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_fmt    = 2'd0;
        in_tag    = 8'd0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;

        // Reset and idle.
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_ovf", 128'(out_ovf), 128'(1'b0));
        for (int i = 0; i < 20; i++) begin
            chk("idle_valid", 128'(out_valid), 128'(1'b0));
            chk("idle_ready", 128'(in_ready), 128'(1'b1));
            tick();
        end

        // Latency: all ones int8, c = 5 -> 21.
        run_one("lat", 2'd1, {8{32'h0101_0101}}, {8{32'h0101_0101}}, {4{32'd5}}, 8'h3C,
                {4{32'd21}}, 1'b0);

        // Formats.
        run_one("fmt1", 2'd1, {8{32'hFFFF_FFFF}}, {8{32'h0101_0101}}, '0, 8'h11,
                {4{32'hFFFF_FFF0}}, 1'b0);
        run_one("fmt2", 2'd2, {8{32'hFFFF_FFFF}}, {8{32'h0101_0101}}, '0, 8'h12,
                {4{32'd4080}}, 1'b0);
        run_one("fmt3", 2'd3, {8{32'hFFFF_FFFF}}, {8{32'h1111_1111}}, '0, 8'h13,
                {4{32'hFFFF_FFE0}}, 1'b0);

        // Lane mapping with int32: rows 1,2; cols 3,-1; c = 10,20,30,40.
        run_one("lanes", 2'd0, {{4{32'd2}}, {4{32'd1}}}, {{4{32'hFFFF_FFFF}}, {4{32'd3}}},
                {32'd40, 32'd30, 32'd20, 32'd10}, 8'h21,
                {32'd32, 32'd54, 32'd16, 32'd22}, 1'b0);

        // Overflow in both directions.
        run_one("ovf_pos", 2'd0, {8{32'h7FFF_FFFF}}, {8{32'h7FFF_FFFF}}, '0, 8'h31,
                ovf_pos_exp, 1'b1);
        run_one("ovf_neg", 2'd0, {8{32'h8000_0000}}, {8{32'h7FFF_FFFF}}, '0, 8'h32,
                ovf_neg_exp, 1'b1);

        // Back-pressure: tags 1..6, d = 100*tag + 4, consumer stalls for 5 cycles.
        sent       = 0;
        rcvd       = 0;
        t          = 0;
        prev_stall = 1'b0;
        prev_d     = '0;
        in_fmt     = 2'd0;
        in_a       = {8{32'd1}};
        in_b       = {8{32'd1}};
        while (rcvd < 6 && t < 60) begin
            out_ready = (t >= 5 && t <= 9) ? 1'b0 : 1'b1;
            in_valid  = (sent < 6);
            in_tag    = 8'(sent + 1);
            in_c      = {4{32'((sent + 1) * 100)}};
            #1;
            if (out_valid && !out_ready) begin
                chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
                if (prev_stall) begin
                    chk("bp_stable", out_d, prev_d);
                end
                prev_stall = 1'b1;
                prev_d     = out_d;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                rcvd++;
                chk("bp_tag", 128'(out_tag), 128'(rcvd));
                chk("bp_d", out_d, {4{32'(rcvd * 100 + 4)}});
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            tick();
            t++;
        end
        chk("bp_count", 128'(rcvd), 128'(6));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("bp_drain", 128'(out_valid), 128'(1'b0));

        // Reset mid-flight: 3 txns, reset sampled on the edge the first would appear.
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        chk("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            chk("post_rst_valid", 128'(out_valid), 128'(1'b0));
            tick();
        end
        run_one("after_rst", 2'd1, {8{32'h0101_0101}}, {8{32'h0101_0101}}, {4{32'd5}}, 8'h5A,
                {4{32'd21}}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
